// File: rtl/cache_controller.sv
// cache_controller: per-CPU 4-line direct-mapped MSI cache with a
// single-outstanding fill/writeback handshake and bus snoop servicing.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for a CPU request; snoops serviced here first
// LOOKUP   | compare captured tag against the indexed line
// WB       | writing the modified victim back to memory
// FILL     | reading the requested line from memory
// DONE     | one-cycle done pulse on result[30] / hit
// WAIT_REL | waiting for the CPU to drop both strobes; snoops serviced
module cache_controller #(
    parameter int LINES = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        writeIn,
    input  logic        readIn,
    input  logic [11:0] tagIn,
    input  logic [15:0] dataIn,
    output logic [30:0] result,
    output logic        hit,
    output logic        memReq,
    output logic        memWe,
    output logic [11:0] memTag,
    output logic [15:0] memWdata,
    input  logic        memAck,
    input  logic [15:0] memRdata,
    output logic        busInv,
    output logic [11:0] busTag,
    input  logic        snoopValid,
    input  logic        snoopWrite,
    input  logic [11:0] snoopTag,
    output logic        snoopBusy,
    output logic        snoopFlush,
    output logic [15:0] flushData
);

    localparam logic [1:0] MSI_I = 2'b00;
    localparam logic [1:0] MSI_S = 2'b01;
    localparam logic [1:0] MSI_M = 2'b10;

    typedef enum logic [2:0] {IDLE, LOOKUP, WB, FILL, DONE, WAIT_REL} fsm_t;

    fsm_t state, state_nxt;

    logic [1:0]  line_msi  [LINES];
    logic [11:0] line_tag  [LINES];
    logic [15:0] line_data [LINES];

    logic        req_write;
    logic [11:0] req_tag;
    logic [15:0] req_data;
    logic [29:0] res_q;
    logic        hit_q;

    logic [1:0]  idx;
    logic [1:0]  cur_msi;
    logic [11:0] cur_tag;
    logic [15:0] cur_data;
    logic        is_hit;
    logic        cpu_req;
    logic        ack_ok;

    logic [1:0]  sidx;
    logic        snoop_take;
    logic        snoop_hit;

    logic        capture;
    logic        line_we;
    logic [1:0]  line_msi_new;
    logic [15:0] line_data_new;
    logic        victim_inv;
    logic        res_load;
    logic [1:0]  res_msi;
    logic [15:0] res_data;
    logic        res_hit;
    logic        inv_set;
    logic        mem_load;
    logic        mem_we_new;
    logic [11:0] mem_tag_new;
    logic [15:0] mem_wdata_new;
    logic        mem_drop;

    assign idx        = req_tag[1:0];
    assign cur_msi    = line_msi[idx];
    assign cur_tag    = line_tag[idx];
    assign cur_data   = line_data[idx];
    assign is_hit     = (cur_msi != MSI_I) && (cur_tag == req_tag);
    assign cpu_req    = writeIn | readIn;
    // a stray ack with no request outstanding is meaningless
    assign ack_ok     = memReq & memAck;

    assign snoopBusy  = !((state == IDLE) || (state == WAIT_REL));
    assign sidx       = snoopTag[1:0];
    assign snoop_take = snoopValid & !snoopBusy;
    assign snoop_hit  = (line_msi[sidx] != MSI_I) && (line_tag[sidx] == snoopTag);

    assign result     = {(state == DONE), res_q};
    assign hit        = (state == DONE) & hit_q;

    // state register
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:     if (cpu_req && !snoop_take) state_nxt = LOOKUP;
            LOOKUP: begin
                if (is_hit)                state_nxt = DONE;
                else if (cur_msi == MSI_M) state_nxt = WB;
                else if (req_write)        state_nxt = DONE;
                else                       state_nxt = FILL;
            end
            WB:       if (ack_ok) state_nxt = req_write ? DONE : FILL;
            FILL:     if (ack_ok) state_nxt = DONE;
            DONE:     state_nxt = WAIT_REL;
            WAIT_REL: if (!cpu_req) state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    // per-state datapath controls for the registered outputs and line array
    always_comb begin
        capture       = 1'b0;
        line_we       = 1'b0;
        line_msi_new  = MSI_I;
        line_data_new = req_data;
        victim_inv    = 1'b0;
        res_load      = 1'b0;
        res_msi       = MSI_I;
        res_data      = req_data;
        res_hit       = 1'b0;
        inv_set       = 1'b0;
        mem_load      = 1'b0;
        mem_we_new    = 1'b0;
        mem_tag_new   = req_tag;
        mem_wdata_new = memWdata;
        mem_drop      = 1'b0;
        case (state)
            IDLE: capture = cpu_req && !snoop_take;
            LOOKUP: begin
                if (is_hit) begin
                    res_load = 1'b1;
                    res_hit  = 1'b1;
                    if (req_write) begin
                        line_we      = 1'b1;
                        line_msi_new = MSI_M;
                        res_msi      = MSI_M;
                        inv_set      = (cur_msi == MSI_S);
                    end else begin
                        res_msi  = cur_msi;
                        res_data = cur_data;
                    end
                end else if (cur_msi == MSI_M) begin
                    mem_load      = 1'b1;
                    mem_we_new    = 1'b1;
                    mem_tag_new   = cur_tag;
                    mem_wdata_new = cur_data;
                end else if (req_write) begin
                    line_we      = 1'b1;
                    line_msi_new = MSI_M;
                    res_load     = 1'b1;
                    res_msi      = MSI_M;
                    inv_set      = 1'b1;
                end else begin
                    mem_load = 1'b1;
                end
            end
            WB: begin
                if (ack_ok) begin
                    mem_drop = 1'b1;
                    if (req_write) begin
                        line_we      = 1'b1;
                        line_msi_new = MSI_M;
                        res_load     = 1'b1;
                        res_msi      = MSI_M;
                        inv_set      = 1'b1;
                    end else begin
                        victim_inv = 1'b1;
                    end
                end
            end
            FILL: begin
                // first FILL cycle after a writeback has memReq low; raise it here
                if (!memReq) begin
                    mem_load = 1'b1;
                end else if (memAck) begin
                    mem_drop      = 1'b1;
                    line_we       = 1'b1;
                    line_msi_new  = MSI_S;
                    line_data_new = memRdata;
                    res_load      = 1'b1;
                    res_msi       = MSI_S;
                    res_data      = memRdata;
                end
            end
            default: ;
        endcase
    end

    // line array, request capture, registered outputs and snoop actions
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < LINES; i++) begin
                line_msi[i]  <= MSI_I;
                line_tag[i]  <= '0;
                line_data[i] <= '0;
            end
            req_write  <= 1'b0;
            req_tag    <= '0;
            req_data   <= '0;
            res_q      <= '0;
            hit_q      <= 1'b0;
            memReq     <= 1'b0;
            memWe      <= 1'b0;
            memTag     <= '0;
            memWdata   <= '0;
            busInv     <= 1'b0;
            busTag     <= '0;
            snoopFlush <= 1'b0;
            flushData  <= '0;
        end else begin
            busInv     <= inv_set;
            snoopFlush <= 1'b0;
            if (inv_set) busTag <= req_tag;
            if (capture) begin
                req_write <= writeIn;
                req_tag   <= tagIn;
                req_data  <= dataIn;
            end
            if (victim_inv) line_msi[idx] <= MSI_I;
            if (line_we) begin
                line_msi[idx]  <= line_msi_new;
                line_tag[idx]  <= req_tag;
                line_data[idx] <= line_data_new;
            end
            if (res_load) begin
                res_q <= {res_msi, req_tag, res_data};
                hit_q <= res_hit;
            end
            if (mem_load) begin
                memReq   <= 1'b1;
                memWe    <= mem_we_new;
                memTag   <= mem_tag_new;
                memWdata <= mem_wdata_new;
            end else if (mem_drop) begin
                memReq <= 1'b0;
            end
            // snoops only run when the FSM is not touching the array
            if (snoop_take && snoop_hit) begin
                if (snoopWrite) begin
                    line_msi[sidx] <= MSI_I;
                end else if (line_msi[sidx] == MSI_M) begin
                    line_msi[sidx] <= MSI_S;
                end
                if (line_msi[sidx] == MSI_M) begin
                    snoopFlush <= 1'b1;
                    flushData  <= line_data[sidx];
                end
            end
        end
    end

endmodule

// File: tb/tb_cache_controller.sv
// Testbench for cache_controller: directed scenarios plus randomized ops,
// checked against a line-level MSI model and a flat memory array.
module tb_cache_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        writeIn, readIn;
    logic [11:0] tagIn;
    logic [15:0] dataIn;
    logic [30:0] result;
    logic        hit;
    logic        memReq, memWe;
    logic [11:0] memTag;
    logic [15:0] memWdata;
    logic        memAck;
    logic [15:0] memRdata;
    logic        busInv;
    logic [11:0] busTag;
    logic        snoopValid, snoopWrite;
    logic [11:0] snoopTag;
    logic        snoopBusy, snoopFlush;
    logic [15:0] flushData;

    int n_cmp = 0;
    int n_err = 0;

    // model: 0 = I, 1 = S, 2 = M
    int          m_st   [4];
    logic [11:0] m_tag  [4];
    logic [15:0] m_data [4];
    logic [15:0] mem    [4096];

    cache_controller #(.LINES(4)) dut (
        .clock(clock), .reset(reset),
        .writeIn(writeIn), .readIn(readIn), .tagIn(tagIn), .dataIn(dataIn),
        .result(result), .hit(hit),
        .memReq(memReq), .memWe(memWe), .memTag(memTag), .memWdata(memWdata),
        .memAck(memAck), .memRdata(memRdata),
        .busInv(busInv), .busTag(busTag),
        .snoopValid(snoopValid), .snoopWrite(snoopWrite), .snoopTag(snoopTag),
        .snoopBusy(snoopBusy), .snoopFlush(snoopFlush), .flushData(flushData)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, obs, exp, $time);
        end
    endtask

    task automatic snoop_model(input bit sw, input logic [11:0] t, output int fl, output logic [15:0] fd);
        int i;
        i  = int'(t[1:0]);
        fl = 0;
        fd = '0;
        if (m_st[i] != 0 && m_tag[i] == t) begin
            if (m_st[i] == 2) begin
                fl = 1;
                fd = m_data[i];
            end
            if (sw) m_st[i] = 0;
            else if (m_st[i] == 2) m_st[i] = 1;
        end
    endtask

    // smode: 0 no snoop, 1 snoop raised together with the request, 2 snoop raised mid-op
    task automatic do_op(input bit wr, input logic [11:0] tag, input logic [15:0] wdata,
                         input int hold_in, input int smode, input bit sw, input logic [11:0] stag);
        int i, off, hold, cyc, done_cnt, done_cyc, phase, dly, last_ack;
        int inv_cnt, flush_cnt, flush_cyc, served, mreq_phases, eflush, n_mem;
        bit ehit, ewb, efill, einv, ack_hi, released, mreq_prev, sn_pending, busy_prev, exp_w;
        logic [11:0] vtag;
        logic [15:0] vdata, edata, efdata;
        logic [1:0]  est;
        logic [29:0] eres;

        off    = (smode == 1) ? 1 : 0;
        hold   = (hold_in < 1 + off) ? 1 + off : hold_in;
        eflush = 0;
        efdata = '0;
        vtag   = '0;
        vdata  = '0;
        if (smode == 1) snoop_model(sw, stag, eflush, efdata);

        i     = int'(tag[1:0]);
        ehit  = (m_st[i] != 0) && (m_tag[i] == tag);
        ewb   = 1'b0;
        efill = 1'b0;
        einv  = 1'b0;
        if (ehit) begin
            if (wr) begin
                einv      = (m_st[i] == 1);
                m_st[i]   = 2;
                m_data[i] = wdata;
            end
        end else begin
            if (m_st[i] == 2) begin
                ewb        = 1'b1;
                vtag       = m_tag[i];
                vdata      = m_data[i];
                mem[vtag]  = vdata;
            end
            m_tag[i] = tag;
            if (wr) begin
                m_st[i]   = 2;
                m_data[i] = wdata;
                einv      = 1'b1;
            end else begin
                efill     = 1'b1;
                m_st[i]   = 1;
                m_data[i] = mem[tag];
            end
        end
        est   = 2'(m_st[i]);
        edata = m_data[i];
        eres  = {est, tag, edata};
        n_mem = int'(ewb) + int'(efill);
        if (smode == 2) snoop_model(sw, stag, eflush, efdata);

        @(negedge clock);
        writeIn = wr;
        readIn  = wr ? 1'($urandom_range(0, 1)) : 1'b1;
        tagIn   = tag;
        dataIn  = wdata;
        sn_pending = 1'b0;
        if (smode == 1) begin
            snoopValid = 1'b1;
            snoopWrite = sw;
            snoopTag   = stag;
            sn_pending = 1'b1;
        end
        busy_prev = snoopBusy;

        cyc = 0; done_cnt = 0; done_cyc = -1; phase = 0; last_ack = -1;
        inv_cnt = 0; flush_cnt = 0; flush_cyc = -1; served = -1; mreq_phases = 0;
        ack_hi = 1'b0; released = 1'b0; mreq_prev = 1'b0;
        dly = $urandom_range(0, 3);

        while (1) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            if (sn_pending && !busy_prev) begin
                sn_pending = 1'b0;
                snoopValid = 1'b0;
                served     = cyc;
            end
            if (snoopFlush) begin
                flush_cnt++;
                flush_cyc = cyc;
                if (eflush != 0) chk("flush_data", 32'(flushData), 32'(efdata));
            end
            if (busInv) begin
                inv_cnt++;
                chk("bus_tag", 32'(busTag), 32'(tag));
            end
            if (result[30]) begin
                done_cnt++;
                done_cyc = cyc;
                if (done_cnt == 1) begin
                    chk("hit", 32'(hit), 32'(ehit));
                    chk("result", 32'(result[29:0]), 32'(eres));
                end
            end
            if (ack_hi) begin
                memAck   = 1'b0;
                ack_hi   = 1'b0;
                last_ack = cyc - 1;
                mreq_prev = 1'b0;
                dly = $urandom_range(0, 3);
                chk("mem_req_after_ack", 32'(memReq), 32'd0);
            end else if (memReq) begin
                if (!mreq_prev) mreq_phases++;
                mreq_prev = 1'b1;
                if (dly == 0) begin
                    exp_w = ewb && (phase == 0);
                    chk("mem_we", 32'(memWe), 32'(exp_w));
                    chk("mem_tag", 32'(memTag), exp_w ? 32'(vtag) : 32'(tag));
                    if (exp_w) chk("mem_wdata", 32'(memWdata), 32'(vdata));
                    memRdata = exp_w ? 16'($urandom) : mem[tag];
                    memAck   = 1'b1;
                    ack_hi   = 1'b1;
                    phase++;
                end else begin
                    dly--;
                end
            end else begin
                mreq_prev = 1'b0;
            end
            if (smode == 2 && cyc == 1) begin
                snoopValid = 1'b1;
                snoopWrite = sw;
                snoopTag   = stag;
                sn_pending = 1'b1;
                chk("snoop_busy_midop", 32'(snoopBusy), 32'd1);
            end
            if (cyc == hold) begin
                writeIn  = 1'b0;
                readIn   = 1'b0;
                released = 1'b1;
            end
            busy_prev = snoopBusy;
            if (done_cnt > 0 && released && !sn_pending && !ack_hi &&
                cyc >= done_cyc + 3 && cyc > hold) break;
            if (cyc > 80) begin
                chk("op_timeout", 32'd1, 32'd0);
                memAck = 1'b0; snoopValid = 1'b0; writeIn = 1'b0; readIn = 1'b0;
                break;
            end
        end

        chk("done_count", 32'(done_cnt), 32'd1);
        chk("mem_phases", 32'(mreq_phases), 32'(n_mem));
        chk("inv_count", 32'(inv_cnt), 32'(einv));
        chk("flush_count", 32'(flush_cnt), 32'(eflush));
        if (eflush != 0) chk("flush_cycle", 32'(flush_cyc), 32'(served));
        if (n_mem == 0) chk("done_latency", 32'(done_cyc), 32'(2 + off));
        else            chk("done_after_ack", 32'(done_cyc), 32'(last_ack + 1));
        chk("result_hold", 32'(result[29:0]), 32'(eres));
    endtask

    task automatic do_snoop(input bit sw, input logic [11:0] t);
        int fl;
        logic [15:0] fd;
        snoop_model(sw, t, fl, fd);
        @(negedge clock);
        snoopValid = 1'b1;
        snoopWrite = sw;
        snoopTag   = t;
        chk("snoop_busy_idle", 32'(snoopBusy), 32'd0);
        @(posedge clock);
        @(negedge clock);
        snoopValid = 1'b0;
        chk("snoop_flush", 32'(snoopFlush), 32'(fl));
        if (fl != 0) chk("snoop_flush_data", 32'(flushData), 32'(fd));
        @(posedge clock);
        @(negedge clock);
        chk("snoop_flush_end", 32'(snoopFlush), 32'd0);
    endtask

    function automatic logic [11:0] rnd_tag();
        return 12'($urandom_range(0, 2) * 32'h124 + $urandom_range(0, 3));
    endfunction

    initial begin
        int k, dn;
        bit w;
        reset = 1'b1; writeIn = 1'b0; readIn = 1'b0; tagIn = '0; dataIn = '0;
        memAck = 1'b0; memRdata = '0; snoopValid = 1'b0; snoopWrite = 1'b0; snoopTag = '0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
        for (int i = 0; i < 4; i++) begin
            m_st[i] = 0; m_tag[i] = '0; m_data[i] = '0;
        end
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_hit", 32'(hit), 32'd0);
        chk("rst_mem_req", 32'(memReq), 32'd0);
        chk("rst_mem_we", 32'(memWe), 32'd0);
        chk("rst_mem_tag", 32'(memTag), 32'd0);
        chk("rst_mem_wdata", 32'(memWdata), 32'd0);
        chk("rst_bus_inv", 32'(busInv), 32'd0);
        chk("rst_bus_tag", 32'(busTag), 32'd0);
        chk("rst_snoop_flush", 32'(snoopFlush), 32'd0);
        chk("rst_flush_data", 32'(flushData), 32'd0);
        chk("rst_snoop_busy", 32'(snoopBusy), 32'd0);
        reset = 1'b0;

        mem[12'h005] = 16'hBEEF;
        do_op(1'b0, 12'h005, 16'h0, 1, 0, 1'b0, 12'h0);
        do_op(1'b0, 12'h005, 16'h0, 10, 0, 1'b0, 12'h0);
        do_op(1'b1, 12'h005, 16'h1234, 1, 0, 1'b0, 12'h0);
        do_op(1'b0, 12'h009, 16'h0, 1, 0, 1'b0, 12'h0);
        do_op(1'b1, 12'h009, 16'hCAFE, 2, 0, 1'b0, 12'h0);
        do_snoop(1'b0, 12'h009);
        do_snoop(1'b1, 12'h009);
        do_op(1'b0, 12'h009, 16'h0, 1, 0, 1'b0, 12'h0);
        do_op(1'b1, 12'h00A, 16'h5A5A, 1, 0, 1'b0, 12'h0);
        do_op(1'b0, 12'h00E, 16'h0, 3, 2, 1'b0, 12'h00A);
        do_op(1'b0, 12'h003, 16'h0, 4, 1, 1'b1, 12'h009);
        do_op(1'b1, 12'h00B, 16'h7777, 2, 2, 1'b1, 12'h00B);

        // reset while a fill is outstanding on line 0 (still invalid here)
        @(negedge clock);
        readIn = 1'b1;
        tagIn  = 12'h7F0;
        k = 0;
        while (!memReq && k < 20) begin
            @(posedge clock);
            @(negedge clock);
            k++;
        end
        chk("fill_req_seen", 32'(memReq), 32'd1);
        chk("fill_req_we", 32'(memWe), 32'd0);
        chk("snoop_busy_fill", 32'(snoopBusy), 32'd1);
        reset  = 1'b1;
        readIn = 1'b0;
        @(posedge clock);
        @(negedge clock);
        chk("rst_abort_mem_req", 32'(memReq), 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) m_st[i] = 0;
        dn = 0;
        repeat (4) begin
            @(posedge clock);
            @(negedge clock);
            if (result[30]) dn++;
        end
        chk("rst_abort_no_done", 32'(dn), 32'd0);
        do_op(1'b0, 12'h005, 16'h0, 1, 0, 1'b0, 12'h0);

        for (int n = 0; n < 200; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                do_snoop(1'($urandom_range(0, 1)), rnd_tag());
            end else begin
                w = 1'($urandom_range(0, 1));
                do_op(w, rnd_tag(), 16'($urandom), int'($urandom_range(1, 6)),
                      int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), rnd_tag());
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cache_controller.md
# cache_controller

Per-CPU cache controller that answers the CPU request port (write/read strobe, 12-bit tag, 16-bit data) and returns a 31-bit `result`. It holds a 4-line direct-mapped MSI cache, fills and writes back through a single-outstanding memory handshake, and services snoops from the shared bus. It sits between one CPU request source and the snooping bus/memory.

## Interface
- `LINES`, default 4: cache lines. Fixed at 4; the index is `tagIn[1:0]`.
- `clock` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `writeIn` in 1: CPU write request level.
- `readIn` in 1: CPU read request level.
- `tagIn` in 12: request address tag.
- `dataIn` in 16: write data.
- `result` out 31: `[30]` done pulse, `[29:28]` line state after op (00 I, 01 S, 10 M), `[27:16]` tag, `[15:0]` data.
- `hit` out 1: valid with `result[30]`; 1 if the op hit.
- `memReq` out 1: memory request.
- `memWe` out 1: 1 = writeback, 0 = fill read.
- `memTag` out 12: memory address.
- `memWdata` out 16: writeback data.
- `memAck` in 1: memory done; one-cycle pulse.
- `memRdata` in 16: fill data, valid with `memAck`.
- `busInv` out 1: one-cycle invalidate broadcast.
- `busTag` out 12: tag for `busInv`.
- `snoopValid` in 1: snoop present; held until serviced.
- `snoopWrite` in 1: 1 = remote write (invalidate), 0 = remote read.
- `snoopTag` in 12: snooped tag.
- `snoopBusy` out 1: 1 when the FSM is outside IDLE/WAIT_REL.
- `snoopFlush` out 1: one-cycle pulse supplying M data to the bus.
- `flushData` out 16: data for `snoopFlush`.

## Operation
- Line fields: valid state (MSI), 12-bit stored tag, 16-bit data. A hit requires state != I and a stored tag equal to the full `tagIn`.
- States: IDLE, LOOKUP, WB, FILL, DONE, WAIT_REL.
- IDLE: if `writeIn|readIn` and no snoop is serviced this cycle, capture the op, tag and data, then go to LOOKUP. Write has priority when both strobes are high. All CPU inputs are ignored outside IDLE.
- LOOKUP:
  - Read hit: go to DONE. State unchanged.
  - Write hit in M: update the data, go to DONE.
  - Write hit in S: update the data, set M, pulse `busInv` with the tag, go to DONE.
  - Miss with victim in M: go to WB.
  - Miss otherwise: read goes to FILL. Write installs the line as M, pulses `busInv`, and goes to DONE.
- WB: `memReq=1`, `memWe=1`, `memTag` = victim tag, `memWdata` = victim data. On `memAck`, the victim becomes I. Then a read goes to FILL; a write installs the line as M, pulses `busInv`, and goes to DONE.
- FILL: `memReq=1`, `memWe=0`, `memTag` = request tag. On `memAck`, line = {S, tag, `memRdata`}, go to DONE.
- DONE: `result[30]=1` and `hit` valid for exactly one cycle, then go to WAIT_REL.
- WAIT_REL: stay until `writeIn` and `readIn` are both 0, then go to IDLE. This prevents a held request from re-executing.
- `result[29:0]` holds its last value between ops.
- Snoop servicing:
  - A snoop is serviced in a cycle with `snoopValid & !snoopBusy`. In IDLE, a snoop takes priority over a CPU request, and that request is accepted on a following cycle.
  - Snoop miss: no action.
  - Remote read hit on M: set S, pulse `snoopFlush` with data.
  - Remote read hit on S: no change.
  - Remote write hit: set I. If the line was M, also pulse `snoopFlush`.

## Timing
- Reset values: every line I with tag and data 0, FSM in IDLE. `result`, `hit`, `memReq`, `memWe`, `memTag`, `memWdata`, `busInv`, `busTag`, `snoopFlush` and `flushData` are all 0. `snoopBusy` is 0.
- Reset mid-operation aborts the op: `memReq` drops on the next edge, and no done pulse is produced.
- Request captured at edge N. For a hit or a write-miss without writeback, `result[30]` is high during the cycle after edge N+1.
- Memory handshake:
  - `memReq`, `memWe`, `memTag` and `memWdata` are registered and held stable until `memAck` is sampled high.
  - `memReq` is low in the cycle after the ack edge.
  - WB to FILL deasserts `memReq` for one cycle.
  - `memAck` is ignored when `memReq=0`.
- `busInv`, `busTag`, `snoopFlush` and `flushData` are registered one-cycle pulses.
- A fill read completes at ack edge M, and `result[30]` is high the cycle after edge M.

## Test plan
- Reset, then read tag 0x005 with memory returning 0xBEEF after 3 cycles -> one FILL `memReq`; `result`={1,01,0x005,0xBEEF}, `hit=0`.
- Repeat the same read held for 10 cycles -> exactly one done pulse (2 cycles after capture) with `hit=1`, and no `memReq`. After release, FSM returns to IDLE.
- Write 0x1234 to tag 0x005 (line S) -> `busInv=1` with `busTag=0x005` for one cycle, `result[29:28]=10`, `hit=1`.
- Read tag 0x009 (same index, victim M) -> WB `memReq` with `memWe=1`, `memTag=0x005`, `memWdata=0x1234`; then FILL with `memTag=0x009`; final state S.
- Snoop read on a tag-0x009 line in M -> `snoopFlush` pulse with its data, state S. A snoop write then sets it to I, and the next CPU read misses.
- Snoop asserted during FILL -> `snoopBusy=1` and the snoop waits until WAIT_REL/IDLE. Reset during FILL -> `memReq=0` on the next edge and all lines I.
